// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the branch resolution controller and its comparator.
package branch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVAL     = 2'd1,
        REDIRECT = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator. Unsigned compares (bltu/bgeu) are only
// built when BRANCH_UNSIGNED_EN is defined; otherwise those codes report illegal.
module branch_cmp
    import branch_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      funct3,
    output logic            taken,
    output logic            illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            BEQ:  taken = (a == b);
            BNE:  taken = (a != b);
            BLT:  taken = ($signed(a) <  $signed(b));
            BGE:  taken = ($signed(a) >= $signed(b));
`ifdef BRANCH_UNSIGNED_EN
            BLTU: taken = (a <  b);
            BGEU: taken = (a >= b);
`else
            BLTU, BGEU: illegal = 1'b1;
`endif
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer: accept, evaluate, then redirect + flush on a mispredict.
// Optional macro BRANCH_UNSIGNED_EN enables bltu/bgeu in the comparator.
module branch_resolve_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_pc,
    input  logic [XLEN-1:0] req_imm,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [2:0]      req_funct3,
    input  logic            req_pred_taken,
    output logic            resp_valid,
    output logic            resp_taken,
    output logic            resp_mispredict,
    output logic            resp_illegal,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic [31:0]     br_count,
    output logic [31:0]     mp_count
);

    localparam logic [3:0]      FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(PC_INC);

    state_t          r_state;
    state_t          w_state_next;
    logic [3:0]      r_flush_cnt;
    logic [3:0]      w_flush_cnt_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [2:0]      r_funct3;
    logic            r_pred_taken;
    logic [XLEN-1:0] r_redirect_pc;
    logic [31:0]     r_br_count;
    logic [31:0]     r_mp_count;

    logic            w_taken;
    logic            w_illegal;
    logic            w_mispredict;
    logic            w_accept;
    logic            w_in_eval;
    logic [XLEN-1:0] w_target;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .a       (r_rs1),
        .b       (r_rs2),
        .funct3  (r_funct3),
        .taken   (w_taken),
        .illegal (w_illegal)
    );

    assign w_in_eval    = (r_state == EVAL);
    assign w_accept     = (r_state == IDLE) && req_valid;
    assign w_mispredict = (w_taken != r_pred_taken);
    assign w_target     = w_taken ? (r_pc + r_imm) : (r_pc + PC_STEP);

    always_comb begin
        w_state_next     = r_state;
        w_flush_cnt_next = r_flush_cnt;
        case (r_state)
            IDLE:     if (req_valid) w_state_next = EVAL;
            EVAL:     w_state_next = w_mispredict ? REDIRECT : IDLE;
            REDIRECT: begin
                w_state_next     = FLUSH;
                w_flush_cnt_next = FLUSH_LOAD;
            end
            FLUSH: begin
                if (r_flush_cnt == 4'd0) w_state_next = IDLE;
                else                     w_flush_cnt_next = r_flush_cnt - 4'd1;
            end
            default:  w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_flush_cnt   <= 4'd0;
            r_pc          <= '0;
            r_imm         <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_funct3      <= 3'd0;
            r_pred_taken  <= 1'b0;
            r_redirect_pc <= '0;
            r_br_count    <= 32'd0;
            r_mp_count    <= 32'd0;
        end else begin
            r_state     <= w_state_next;
            r_flush_cnt <= w_flush_cnt_next;
            // Operands are captured only on the handshake edge.
            if (w_accept) begin
                r_pc         <= req_pc;
                r_imm        <= req_imm;
                r_rs1        <= req_rs1;
                r_rs2        <= req_rs2;
                r_funct3     <= req_funct3;
                r_pred_taken <= req_pred_taken;
            end
            if (w_in_eval) begin
                r_redirect_pc <= w_target;
                r_br_count    <= r_br_count + 32'd1;
                if (w_mispredict) r_mp_count <= r_mp_count + 32'd1;
            end
        end
    end

    assign req_ready       = (r_state == IDLE);
    assign resp_valid      = w_in_eval;
    assign resp_taken      = w_in_eval & w_taken;
    assign resp_mispredict = w_in_eval & w_mispredict;
    assign resp_illegal    = w_in_eval & w_illegal;
    assign redirect_valid  = (r_state == REDIRECT);
    assign redirect_pc     = r_redirect_pc;
    assign flush           = (r_state == FLUSH);
    assign br_count        = r_br_count;
    assign mp_count        = r_mp_count;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: vector table plus reset, back-to-back and wrap sequences.
module tb_branch_resolve_ctrl;

    localparam int XLEN = 32;
    localparam int FC   = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] req_imm;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;
    logic [2:0]      req_funct3;
    logic            req_pred_taken;
    logic            resp_valid;
    logic            resp_taken;
    logic            resp_mispredict;
    logic            resp_illegal;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;
    logic [31:0]     br_count;
    logic [31:0]     mp_count;

    branch_resolve_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_pc          (req_pc),
        .req_imm         (req_imm),
        .req_rs1         (req_rs1),
        .req_rs2         (req_rs2),
        .req_funct3      (req_funct3),
        .req_pred_taken  (req_pred_taken),
        .resp_valid      (resp_valid),
        .resp_taken      (resp_taken),
        .resp_mispredict (resp_mispredict),
        .resp_illegal    (resp_illegal),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .flush           (flush),
        .br_count        (br_count),
        .mp_count        (mp_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        pred;
        logic        e_taken;
        logic        e_ill;
        logic        e_mp;
        logic [31:0] e_rpc;
    } vec_t;

    typedef struct {
        logic        taken;
        logic        ill;
        logic        mp;
        logic [31:0] rpc;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[9];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl_br = 32'd0;
    logic [31:0] mdl_mp = 32'd0;

    function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] pc, input logic [31:0] imm, input logic pred,
                                input logic e_taken, input logic e_ill, input logic e_mp,
                                input logic [31:0] e_rpc);
        vec_t v;
        v.f3 = f3; v.rs1 = rs1; v.rs2 = rs2; v.pc = pc; v.imm = imm; v.pred = pred;
        v.e_taken = e_taken; v.e_ill = e_ill; v.e_mp = e_mp; v.e_rpc = e_rpc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic drive(input vec_t v);
        req_pc         = v.pc;
        req_imm        = v.imm;
        req_rs1        = v.rs1;
        req_rs2        = v.rs2;
        req_funct3     = v.f3;
        req_pred_taken = v.pred;
        req_valid      = 1'b1;
    endtask

    task automatic run_branch(input vec_t v, input string tag);
        exp_t e;
        exp_t got;
        wait_ready();
        drive(v);
        e.taken = v.e_taken; e.ill = v.e_ill; e.mp = v.e_mp; e.rpc = v.e_rpc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        // Scramble inputs after acceptance; the latched copy must be used.
        req_valid      = 1'b0;
        req_rs1        = $urandom;
        req_rs2        = $urandom;
        req_pc         = $urandom;
        req_imm        = $urandom;
        req_funct3     = 3'($urandom_range(0, 7));
        req_pred_taken = ~v.pred;
        @(negedge clk);
        chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
        got = (sb.size() > 0) ? sb.pop_front() : e;
        chk({tag, ".taken"}, 32'(resp_taken), 32'(got.taken));
        chk({tag, ".mispredict"}, 32'(resp_mispredict), 32'(got.mp));
        chk({tag, ".illegal"}, 32'(resp_illegal), 32'(got.ill));
        chk({tag, ".ready_eval"}, 32'(req_ready), 32'd0);
        mdl_br = mdl_br + 32'd1;
        if (got.mp) mdl_mp = mdl_mp + 32'd1;
        @(negedge clk);
        chk({tag, ".resp_valid_off"}, 32'(resp_valid), 32'd0);
        if (got.mp) begin
            chk({tag, ".redirect_valid"}, 32'(redirect_valid), 32'd1);
            chk({tag, ".redirect_pc"}, redirect_pc, got.rpc);
            chk({tag, ".ready_redirect"}, 32'(req_ready), 32'd0);
            chk({tag, ".flush_redirect"}, 32'(flush), 32'd0);
            for (int i = 0; i < FC; i++) begin
                @(negedge clk);
                chk({tag, ".flush"}, 32'(flush), 32'd1);
                chk({tag, ".redirect_off"}, 32'(redirect_valid), 32'd0);
            end
            @(negedge clk);
            chk({tag, ".flush_end"}, 32'(flush), 32'd0);
            chk({tag, ".ready_after"}, 32'(req_ready), 32'd1);
        end else begin
            chk({tag, ".no_redirect"}, 32'(redirect_valid), 32'd0);
            chk({tag, ".ready_k2"}, 32'(req_ready), 32'd1);
            chk({tag, ".no_flush"}, 32'(flush), 32'd0);
        end
        chk({tag, ".br_count"}, br_count, mdl_br);
        chk({tag, ".mp_count"}, mp_count, mdl_mp);
        $display("TXN %s f3=%b taken=%0b mp=%0b ill=%0b br=%0d mp_cnt=%0d",
                 tag, v.f3, got.taken, got.mp, got.ill, br_count, mp_count);
    endtask

    initial begin
        exp_t e;
        exp_t got;
        int   acc;
        int   rsp;

        vecs[0] = mk(3'b000, 32'h5, 32'h5, 32'h100, 32'h20, 1'b1, 1'b1, 1'b0, 1'b0, 32'h120);
        vecs[1] = mk(3'b100, 32'hFFFFFFFF, 32'h1, 32'h200, 32'hFFFFFFF0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1F0);
        vecs[2] = mk(3'b101, 32'h1, 32'h80000000, 32'hFFFFFFFC, 32'h8, 1'b0, 1'b1, 1'b0, 1'b1, 32'h4);
`ifdef BRANCH_UNSIGNED_EN
        vecs[3] = mk(3'b110, 32'h1, 32'hFFFFFFFF, 32'h300, 32'h40, 1'b0, 1'b1, 1'b0, 1'b1, 32'h340);
        vecs[6] = mk(3'b111, 32'hFFFFFFFF, 32'h1, 32'h600, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 32'h610);
`else
        vecs[3] = mk(3'b110, 32'h1, 32'hFFFFFFFF, 32'h300, 32'h40, 1'b0, 1'b0, 1'b1, 1'b0, 32'h304);
        vecs[6] = mk(3'b111, 32'hFFFFFFFF, 32'h1, 32'h600, 32'h10, 1'b1, 1'b0, 1'b1, 1'b1, 32'h604);
`endif
        vecs[4] = mk(3'b001, 32'h7, 32'h7, 32'h400, 32'h80, 1'b1, 1'b0, 1'b0, 1'b1, 32'h404);
        vecs[5] = mk(3'b010, 32'h3, 32'h3, 32'h500, 32'h80, 1'b1, 1'b0, 1'b1, 1'b1, 32'h504);
        vecs[7] = mk(3'b101, 32'hFFFFFFFF, 32'h1, 32'h700, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 32'h704);
        vecs[8] = mk(3'b100, 32'h3, 32'h3, 32'h800, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 32'h804);

        rst = 1'b1; req_valid = 1'b0; req_pc = '0; req_imm = '0;
        req_rs1 = '0; req_rs2 = '0; req_funct3 = 3'd0; req_pred_taken = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset.req_ready", 32'(req_ready), 32'd1);
        chk("reset.resp_valid", 32'(resp_valid), 32'd0);
        chk("reset.redirect_valid", 32'(redirect_valid), 32'd0);
        chk("reset.redirect_pc", redirect_pc, 32'd0);
        chk("reset.flush", 32'(flush), 32'd0);
        chk("reset.br_count", br_count, 32'd0);
        chk("reset.mp_count", mp_count, 32'd0);

        for (int i = 0; i < 9; i++) run_branch(vecs[i], $sformatf("vec%0d", i));

        // Reset asserted during the REDIRECT cycle aborts the flush.
        wait_ready();
        drive(vecs[1]);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rstmid.mispredict", 32'(resp_mispredict), 32'd1);
        @(negedge clk);
        chk("rstmid.redirect_valid", 32'(redirect_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid.redirect_hold", 32'(redirect_valid), 32'd1);
        @(negedge clk);
        chk("rstmid.flush", 32'(flush), 32'd0);
        chk("rstmid.req_ready", 32'(req_ready), 32'd1);
        chk("rstmid.redirect_off", 32'(redirect_valid), 32'd0);
        chk("rstmid.br_count", br_count, 32'd0);
        chk("rstmid.mp_count", mp_count, 32'd0);
        rst = 1'b0;
        mdl_br = 32'd0;
        mdl_mp = 32'd0;
        @(negedge clk);
        chk("rstmid.flush_after", 32'(flush), 32'd0);
        $display("TXN rstmid flush=%0b ready=%0b br=%0d mp=%0d", flush, req_ready, br_count, mp_count);

        // Back-to-back: req_valid held high, three correctly predicted bne.
        wait_ready();
        drive(mk(3'b001, 32'h1, 32'h2, 32'h900, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0, 32'h940));
        e.taken = 1'b1; e.ill = 1'b0; e.mp = 1'b0; e.rpc = 32'h940;
        acc = 0;
        rsp = 0;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("b2b.ready_c%0d", c), 32'(req_ready), 32'((c % 2) == 0));
            chk($sformatf("b2b.resp_c%0d", c), 32'(resp_valid), 32'((c % 2) == 1));
            if (req_ready && req_valid) begin
                sb.push_back(e);
                acc++;
            end
            if (resp_valid) begin
                rsp++;
                got = (sb.size() > 0) ? sb.pop_front() : e;
                chk("b2b.taken", 32'(resp_taken), 32'(got.taken));
                chk("b2b.mispredict", 32'(resp_mispredict), 32'(got.mp));
            end
            if (c == 5) req_valid = 1'b0;
            @(negedge clk);
        end
        chk("b2b.accepts", 32'(acc), 32'd3);
        chk("b2b.responses", 32'(rsp), 32'd3);
        mdl_br = mdl_br + 32'd3;
        chk("b2b.br_count", br_count, mdl_br);
        chk("b2b.mp_count", mp_count, mdl_mp);
        $display("TXN b2b accepts=%0d responses=%0d br=%0d", acc, rsp, br_count);

        // Counter wrap via deposit while idle.
        wait_ready();
        force dut.r_br_count = 32'hFFFFFFFF;
        @(negedge clk);
        release dut.r_br_count;
        #1;
        chk("wrap.deposit", br_count, 32'hFFFFFFFF);
        mdl_br = 32'hFFFFFFFF;
        run_branch(vecs[0], "wrap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/branch_resolve_ctrl.md
# branch_resolve_ctrl

Sequencing controller for conditional-branch resolution. Accepts one branch request at a time over a valid/ready handshake and latches its operands. It evaluates the condition through a private comparator instance and reports taken/mispredict status. On a mispredict it drives a one-cycle fetch redirect followed by a fixed-length pipeline flush. It sits between decode/issue and the fetch unit, and owns the branch comparator resource.

## Interface
Parameters:
- XLEN, 32: operand and PC width.
- FLUSH_CYCLES, 2: number of cycles `flush` is held after a redirect. Legal range is 1..15.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  branch request present.
- req_ready  output  1  controller can accept a request; high only in IDLE.
- req_pc  input  XLEN  PC of the branch instruction.
- req_imm  input  XLEN  sign-extended B-type offset.
- req_rs1, req_rs2  input  XLEN  compare operands.
- req_funct3  input  3  branch type.
- req_pred_taken  input  1  fetch-stage prediction.
- resp_valid  output  1  result valid; high for exactly one cycle per request.
- resp_taken  output  1  resolved direction.
- resp_mispredict  output  1  resolved direction differs from the prediction.
- resp_illegal  output  1  funct3 not supported.
- redirect_valid  output  1  fetch redirect strobe.
- redirect_pc  output  XLEN  corrected fetch address.
- flush  output  1  kill younger instructions.
- br_count  output  32  resolved branches, wrapping.
- mp_count  output  32  mispredicts, wrapping.

## Operation
- States:
  - IDLE: req_ready=1.
  - EVAL: compare the latched operands.
  - REDIRECT: drive the fetch redirect.
  - FLUSH: hold flush with a down-counter.
- Transitions:
  - IDLE -> EVAL on req_valid && req_ready. Latch pc, imm, rs1, rs2, funct3, pred_taken.
  - EVAL -> REDIRECT if mispredict, else EVAL -> IDLE.
  - REDIRECT -> FLUSH, loading the counter with FLUSH_CYCLES-1.
  - FLUSH -> IDLE when the counter is 0; otherwise decrement.
- Condition evaluation, by funct3:
  - 000 beq: rs1 == rs2.
  - 001 bne: rs1 != rs2.
  - 100 blt: signed rs1 < rs2.
  - 101 bge: signed rs1 >= rs2.
  - 110/111: see Configuration.
  - Any other code: taken=0, illegal=1. The prediction is still compared against taken=0.
- redirect_pc:
  - If taken: pc + imm, computed modulo 2^XLEN (wrap-around, no overflow flag).
  - If not taken: pc + 4, also modulo 2^XLEN.
- Counters, incremented at the EVAL->next edge:
  - br_count increments on every EVAL, including illegal codes.
  - mp_count increments only on a mispredict.
  - Both wrap from 0xFFFFFFFF to 0.

## Timing
- Reset values: state IDLE; req_ready=1; every other output 0, including both counters and redirect_pc.
- Reset asserted in any state:
  - Takes effect at the next edge: state returns to IDLE and any redirect or flush in progress is aborted.
  - While rst is high, outputs keep the values they hold until that edge.
- Request accepted at edge k:
  - resp_* are valid during cycle k+1, the EVAL cycle.
  - resp_valid is 0 in every other state.
- Correct prediction: req_ready returns to 1 in cycle k+2. Throughput is one branch per 2 cycles.
- Mispredict:
  - redirect_valid=1 in cycle k+2 only; redirect_pc is valid only while redirect_valid=1.
  - flush=1 in cycles k+3 .. k+2+FLUSH_CYCLES.
  - req_ready=1 again in cycle k+3+FLUSH_CYCLES.
- req_valid while req_ready=0 is ignored, not queued. The requester holds its inputs until the handshake occurs.
- Inputs are not sampled outside the accept edge. Operand changes after acceptance have no effect.

## Configuration
- BRANCH_UNSIGNED_EN:
  - Defined: funct3 110 is bltu (unsigned rs1 < rs2) and 111 is bgeu (unsigned rs1 >= rs2). Both are legal.
  - Undefined: 110/111 are treated as illegal (taken=0, resp_illegal=1). No unsigned comparator is built.

## Structure
- Package branch_ctrl_pkg holds:
  - the state enum (IDLE, EVAL, REDIRECT, FLUSH);
  - localparams for the funct3 codes (BEQ, BNE, BLT, BGE, BLTU, BGEU);
  - the PC increment constant 4.
- Sub-module branch_cmp: purely combinational.
  - Inputs: a, b, funct3.
  - Outputs: taken, illegal.
  - Honours BRANCH_UNSIGNED_EN.
  - Instantiated once inside the controller.

## Test plan
- Reset mid-operation:
  - Stimulus: after a mispredict, assert rst in the REDIRECT cycle (cycle k+2).
  - Response: flush never asserts, state is IDLE with req_ready=1 at the next edge, and br_count=mp_count=0.
- Correctly predicted beq:
  - Stimulus: beq, rs1=rs2=0x5, pc=0x100, imm=0x20, pred_taken=1.
  - Response: resp_valid/resp_taken=1 and mispredict=0 in k+1; no redirect; req_ready=1 in k+2; br_count=1.
- Mispredicted blt:
  - Stimulus: blt, rs1=0xFFFFFFFF, rs2=0x1, pc=0x200, imm=0xFFFFFFF0, pred_taken=0.
  - Response: taken=1, mispredict=1; redirect_pc=0x1F0 in k+2; flush in k+3..k+4; mp_count=1.
- PC wrap-around:
  - Stimulus: bge, rs1=0x1, rs2=0x80000000, pc=0xFFFFFFFC, imm=0x8, pred_taken=0.
  - Response: taken=1; redirect_pc=0x00000004.
- Unsigned codes under the macro:
  - Stimulus: bltu, rs1=0x1, rs2=0xFFFFFFFF, pred_taken=0.
  - With BRANCH_UNSIGNED_EN defined: taken=1, mispredict=1.
  - With BRANCH_UNSIGNED_EN undefined: resp_illegal=1, taken=0, mispredict=0.
- Back-to-back requests:
  - Stimulus: req_valid held high with 3 correctly predicted bne requests.
  - Response: accepts occur every 2 cycles, and req_valid while req_ready=0 is ignored.
  - Counter wrap: with br_count forced via hierarchical deposit to 0xFFFFFFFF, the next branch reads 0.
